warp_lsu: RTL
=============

# warp_lsu

Per-warp load/store unit. It sits between the warp register file and the shared data-memory port. It captures per-thread address and store-data operands during the request phase of a memory instruction, then issues one memory transaction per enabled thread, serialised in ascending thread order. It returns per-thread load results on `lsu_out`, which the register file writes back during the update phase.

## Interface
- `THREADS_PER_WARP`, default 4: threads per warp; sets the lane count and the thread-pointer width of `$clog2(THREADS_PER_WARP)`, minimum 1 bit.
- `clk` input 1: clock; all state is updated on the rising edge.
- `reset` input 1: asynchronous, active-low.
- `warp_enable` input 1: this warp owns the pipeline this cycle.
- `warp_state` input `warp_state_t`: current warp phase (`WARP_REQUEST`, `WARP_UPDATE`, others).
- `thread_enable` input `THREADS_PER_WARP`: execution mask.
- `DMemEN` input 1: the instruction is a memory operation.
- `DMemRW` input 1: 0 = load, 1 = store.
- `imm` input `data_t`: signed address offset.
- `rs1` input `data_t [THREADS_PER_WARP-1:0]`: per-thread base address.
- `rs2` input `data_t [THREADS_PER_WARP-1:0]`: per-thread store data.
- `mem_req_valid` output 1: request valid.
- `mem_req_ready` input 1: memory accepts the request.
- `mem_req_we` output 1: write enable.
- `mem_req_addr` output `data_t`: byte address.
- `mem_req_wdata` output `data_t`: store data.
- `mem_resp_valid` input 1: response or write-ack valid.
- `mem_resp_rdata` input `data_t`: load data.
- `lsu_out` output `data_t [THREADS_PER_WARP-1:0]`: per-thread load results.
- `lsu_busy` output 1: an operation is in flight (states REQ or WAIT).
- `lsu_done` output 1: all enabled threads are complete; results are valid.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- **IDLE → capture.** The capture condition is `warp_enable && warp_state==WARP_REQUEST && DMemEN`. When it holds, the block latches:
  - `addr[t] = rs1[t] + imm` for every lane, 32-bit modulo with wrap and no overflow flag;
  - `wdata[t] = rs2[t]`, `thread_enable` as `pend_mask`, and `DMemRW` as `op_we`.
- **Capture target.** If the latched mask is non-zero, go to REQ with the pointer at the lowest set bit. If the mask is zero, go straight to DONE.
- **REQ.**
  - `mem_req_valid=1`; `mem_req_addr`, `mem_req_wdata` and `mem_req_we` come from the current lane.
  - When `mem_req_ready=1`, clear `pend_mask[ptr]` and go to WAIT.
  - Outputs stay stable while `mem_req_ready=0`.
- **WAIT.**
  - `mem_req_valid=0`.
  - When `mem_resp_valid=1`:
    - for a load, write `lsu_out[ptr] <= mem_resp_rdata`; for a store, `lsu_out` is unchanged;
    - move the pointer to the lowest remaining set bit of `pend_mask` and go to REQ;
    - if no bit remains, go to DONE.
  - A `mem_resp_valid` outside WAIT is ignored.
- **DONE.** `lsu_done=1`. Exit to IDLE on `warp_enable && warp_state==WARP_UPDATE`. `lsu_out` holds its value until the next load overwrites a lane.
- **Disabled lanes.** Lanes with `thread_enable=0` at capture are never issued, and their `lsu_out` entries keep their previous values.
- **No disturbance.** Capture inputs are ignored in REQ, WAIT and DONE. Changes to `thread_enable`, `rs1`, `rs2` or `imm` after capture do not disturb the operation in flight.
- **`warp_enable` low.** The transaction continues; the memory handshake is independent of warp ownership.

## Timing
- **Reset values.** `mem_req_valid=0`, `mem_req_we=0`, `mem_req_addr=0`, `mem_req_wdata=0`, all `lsu_out=0`, `lsu_busy=0`, `lsu_done=0`; internal masks and pointer are 0.
- **Reset asserted mid-transaction.** `mem_req_valid` deasserts immediately (asynchronous clear) and any outstanding response is dropped.
- **Cycle counts.**
  - First `mem_req_valid` appears the cycle after the capture edge.
  - With memory that is always ready and responds one cycle after acceptance, each lane costs 2 cycles.
  - For N enabled lanes, `lsu_done` asserts 2N+1 cycles after the capture edge; for N=0 it asserts 1 cycle after.
- **Output drive.** `mem_req_*` and `lsu_done` are driven from registers; there is no combinational path from any input to any output.
- **Outstanding transactions.** At most one transaction is outstanding; the next request is issued the cycle after the response.
- **Ready and response in the same cycle.** The FSM handles acceptance first. The response is accepted only in WAIT, so it cannot complete the request just issued.

## Test plan
- **Four-lane load.** T=4, mask 4'b1111, load, `rs1={0x10,0x20,0x30,0x40}`, `imm=4`, memory returns addr+0x1000.
  - Addresses must be 0x14, 0x24, 0x34, 0x44 in that order.
  - `lsu_out={0x1014,0x1024,0x1034,0x1044}`.
  - `lsu_done` is high 9 cycles after capture.
- **Sparse-mask store.** Mask 4'b1010, store, `rs2={..,0xBB,..,0xDD}`.
  - Exactly 2 requests are issued, to lanes 1 then 3, with `mem_req_we=1` and wdata 0xBB then 0xDD.
  - `lsu_out` is unchanged.
- **Zero mask.** Mask 4'b0000.
  - No `mem_req_valid` ever.
  - `lsu_done=1` one cycle after capture and cleared after the `WARP_UPDATE` cycle.
- **Backpressure.** Hold `mem_req_ready=0` for 5 cycles on lane 0.
  - `mem_req_valid`, addr and wdata stay constant for those 5 cycles.
  - Exactly one handshake occurs.
- **Wrap and negative offset.** `rs1=0xFFFFFFFC`, `imm=8` gives addr 0x00000004. `rs1=0x100`, `imm=-4` gives 0xFC.
- **Reset mid-operation.** Assert reset in WAIT of lane 1 of 4.
  - All outputs are 0 within the same cycle.
  - After release the FSM is in IDLE and a new capture works normally.

Source files
------------

// File: rtl/warp_lsu.sv
// rtl/warp_lsu.sv - per-warp load/store unit serialising lane accesses onto one memory port

package warp_lsu_pkg;
  typedef logic [31:0] data_t;

  typedef enum logic [1:0] {
    WARP_IDLE    = 2'd0,
    WARP_REQUEST = 2'd1,
    WARP_EXECUTE = 2'd2,
    WARP_UPDATE  = 2'd3
  } warp_state_t;
endpackage

module warp_lsu
  import warp_lsu_pkg::*;
#(
  parameter int THREADS_PER_WARP = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               warp_enable,
  input  warp_state_t                        warp_state,
  input  logic [THREADS_PER_WARP-1:0]        thread_enable,
  input  logic                               DMemEN,
  input  logic                               DMemRW,
  input  data_t                              imm,
  input  data_t [THREADS_PER_WARP-1:0]       rs1,
  input  data_t [THREADS_PER_WARP-1:0]       rs2,
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  output logic                               mem_req_we,
  output data_t                              mem_req_addr,
  output data_t                              mem_req_wdata,
  input  logic                               mem_resp_valid,
  input  data_t                              mem_resp_rdata,
  output data_t [THREADS_PER_WARP-1:0]       lsu_out,
  output logic                               lsu_busy,
  output logic                               lsu_done
);

  localparam int PTR_W = (THREADS_PER_WARP > 1) ? $clog2(THREADS_PER_WARP) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  lsu_state_t                    state_q, state_d;
  logic [THREADS_PER_WARP-1:0]   pend_mask_q, pend_mask_d;
  logic [PTR_W-1:0]              ptr_q, ptr_d;
  logic                          op_we_q, op_we_d;
  data_t [THREADS_PER_WARP-1:0]  addr_q, addr_d;
  data_t [THREADS_PER_WARP-1:0]  wdata_q, wdata_d;
  data_t [THREADS_PER_WARP-1:0]  lsu_out_q, lsu_out_d;
  logic                          req_valid_q, req_valid_d;
  logic                          req_we_q, req_we_d;
  data_t                         req_addr_q, req_addr_d;
  data_t                         req_wdata_q, req_wdata_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic                          capture;
  logic [PTR_W-1:0]              first_ptr;
  logic [PTR_W-1:0]              next_ptr;

  // Index of the lowest set bit; lanes are always served in ascending order.
  function automatic logic [PTR_W-1:0] lowest_set(input logic [THREADS_PER_WARP-1:0] m);
    lowest_set = '0;
    for (int i = THREADS_PER_WARP - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = PTR_W'(i);
    end
  endfunction

  assign capture   = warp_enable && (warp_state == WARP_REQUEST) && DMemEN;
  assign first_ptr = lowest_set(thread_enable);
  assign next_ptr  = lowest_set(pend_mask_q);

  // Next-state logic: operand capture, request sequencing and response writeback.
  always_comb begin
    state_d     = state_q;
    pend_mask_d = pend_mask_q;
    ptr_d       = ptr_q;
    op_we_d     = op_we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lsu_out_d   = lsu_out_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (capture) begin
          for (int t = 0; t < THREADS_PER_WARP; t++) begin
            addr_d[t]  = rs1[t] + imm;
            wdata_d[t] = rs2[t];
          end
          pend_mask_d = thread_enable;
          op_we_d     = DMemRW;
          if (|thread_enable) begin
            // Present the first lane straight from the inputs so the request
            // is registered on the capture edge itself.
            ptr_d       = first_ptr;
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            req_we_d    = DMemRW;
            req_addr_d  = rs1[first_ptr] + imm;
            req_wdata_d = rs2[first_ptr];
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_REQ: begin
        if (mem_req_ready) begin
          pend_mask_d[ptr_q] = 1'b0;
          req_valid_d        = 1'b0;
          state_d            = S_WAIT;
        end
      end

      S_WAIT: begin
        if (mem_resp_valid) begin
          if (!op_we_q) begin
            lsu_out_d[ptr_q] = mem_resp_rdata;
          end
          if (|pend_mask_q) begin
            ptr_d       = next_ptr;
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            req_we_d    = op_we_q;
            req_addr_d  = addr_q[next_ptr];
            req_wdata_d = wdata_q[next_ptr];
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (warp_enable && (warp_state == WARP_UPDATE)) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_REQ) || (state_d == S_WAIT);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pend_mask_q <= '0;
      ptr_q       <= '0;
      op_we_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lsu_out_q   <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_mask_q <= pend_mask_d;
      ptr_q       <= ptr_d;
      op_we_q     <= op_we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lsu_out_q   <= lsu_out_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_we    = req_we_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign lsu_out       = lsu_out_q;
  assign lsu_busy      = busy_q;
  assign lsu_done      = done_q;

endmodule
